// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer.
// Holds the default payload, control and stall-counter widths, the record
// layout of one buffer slot (valid, ctrl, data) and a small helper that
// turns the two slot valid bits into an occupancy count.
package pipe_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int CTRL_W_DEF = 24;
    localparam int CNT_W_DEF  = 16;

    // One buffer slot at the default widths.
    typedef struct packed {
        logic                  valid;
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] data;
    } slot_t;

    // Number of valid entries held across the main and skid slots.
    function automatic logic [1:0] countValid(input logic mainValid, input logic skidValid);
        return {1'b0, mainValid} + {1'b0, skidValid};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// Single buffer slot: a valid bit plus ctrl and data fields.
// Ports:
//   clk, rst           - clock and asynchronous active-high reset (clears everything)
//   i_clr              - synchronous invalidate; leaves ctrl/data untouched
//   i_load             - load i_ctrl/i_data and mark the slot valid
//   i_ctrl, i_data     - values to load
//   o_valid, o_ctrl, o_data - current slot contents
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Clear wins over load so a flush can never be overridden by a move.
    // The payload only changes on a load, so a held entry stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages.
// The main slot drives the outputs; the skid slot catches the one entry that
// can arrive while the main slot is blocked, so in_ready can come straight
// from a register instead of from out_ready.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   in_valid, in_ready             - upstream handshake (in_ready = skid empty)
//   in_ctrl, in_data               - incoming entry
//   flush                          - drop every held entry on the next edge
//   out_valid, out_ready           - downstream handshake
//   out_ctrl, out_data             - main-slot entry (ctrl zeroed for bubbles)
//   occupancy                      - number of held entries, 0..2
//   stall_cnt                      - saturating count of blocked output cycles
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              w_mainValid;
    logic [CTRL_W-1:0] w_mainCtrl;
    logic [DATA_W-1:0] w_mainData;
    logic              w_skidValid;
    logic [CTRL_W-1:0] w_skidCtrl;
    logic [DATA_W-1:0] w_skidData;

    logic              w_accept;
    logic              w_mainFree;
    logic              w_mainClr;
    logic              w_mainLoad;
    logic [CTRL_W-1:0] w_mainLoadCtrl;
    logic [DATA_W-1:0] w_mainLoadData;
    logic              w_skidClr;
    logic              w_skidLoad;

    logic [CNT_W-1:0]  r_stallCnt;

    // in_ready is the inverted skid valid register, so no combinational path
    // from out_ready reaches the upstream stage.
    assign in_ready = ~w_skidValid;
    assign w_accept = in_valid & ~w_skidValid;

    // Main slot is free to take something new when it is empty or being consumed.
    assign w_mainFree = ~w_mainValid | out_ready;

    // A waiting skid entry always goes to main before new input so order is kept;
    // the skid is never full while input is accepted, so the two cannot collide.
    assign w_mainLoad     = ~flush & w_mainFree & (w_skidValid | w_accept);
    assign w_mainClr      = flush | (w_mainFree & ~w_skidValid & ~w_accept);
    assign w_mainLoadCtrl = w_skidValid ? w_skidCtrl : in_ctrl;
    assign w_mainLoadData = w_skidValid ? w_skidData : in_data;

    // Skid only fills when main is blocked, and empties whenever it moves to main.
    assign w_skidLoad = ~flush & ~w_mainFree & w_accept;
    assign w_skidClr  = flush | (w_mainFree & w_skidValid);

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_mainSlot (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_mainClr),
        .i_load  (w_mainLoad),
        .i_ctrl  (w_mainLoadCtrl),
        .i_data  (w_mainLoadData),
        .o_valid (w_mainValid),
        .o_ctrl  (w_mainCtrl),
        .o_data  (w_mainData)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skidSlot (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_skidClr),
        .i_load  (w_skidLoad),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skidValid),
        .o_ctrl  (w_skidCtrl),
        .o_data  (w_skidData)
    );

    // Count cycles where a valid output is held back; stick at all-ones.
    // Flush deliberately leaves the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_mainValid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // A bubble carries zero control so it can never write architectural state.
    assign out_valid = w_mainValid;
    assign out_ctrl  = w_mainValid ? w_mainCtrl : '0;
    assign out_data  = w_mainData;
    assign occupancy = countValid(w_mainValid, w_skidValid);
    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, backpressure, flush,
// bubble control zeroing, stall counter saturation and asynchronous reset.
module tb_pipe_stage_buf;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int vectorCount;
    int missCount;

    pipe_stage_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive every DUT input at once.
    task automatic applyStimulus(input logic valid, input logic [CTRL_W-1:0] ctrl,
                                 input logic [DATA_W-1:0] data, input logic outReady,
                                 input logic flushIn);
        in_valid  = valid;
        in_ctrl   = ctrl;
        in_data   = data;
        out_ready = outReady;
        flush     = flushIn;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across one edge, check the reset state, then release.
    task automatic doReset(input string tag);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput({tag, "_outValid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_inReady"},  64'(in_ready),  64'd1);
        checkOutput({tag, "_occ"},      64'(occupancy), 64'd0);
        checkOutput({tag, "_stall"},    64'(stall_cnt), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        #2;
        checkOutput("rst_outCtrl", 64'(out_ctrl), 64'd0);
        checkOutput("rst_outData", 64'(out_data), 64'd0);
        doReset("rst");

        // Streaming: one entry per cycle, each visible one edge after it is offered.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("stream%0d_data", i),  64'(out_data),  64'(i));
            checkOutput($sformatf("stream%0d_ctrl", i),  64'(out_ctrl),  64'(i));
            checkOutput($sformatf("stream%0d_ready", i), 64'(in_ready),  64'd1);
            checkOutput($sformatf("stream%0d_stall", i), 64'(stall_cnt), 64'd0);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("streamEnd_valid", 64'(out_valid), 64'd0);
        checkOutput("streamEnd_occ",   64'(occupancy), 64'd0);

        // Backpressure: A into main, B into skid, then three blocked edges.
        doReset("bpRst");
        applyStimulus(1'b1, 8'h1A, 32'h0000_00AA, 1'b0, 1'b0);
        tick();
        checkOutput("bpA_stall", 64'(stall_cnt), 64'd0);
        applyStimulus(1'b1, 8'h1B, 32'h0000_00BB, 1'b0, 1'b0);
        tick();
        checkOutput("bpB_occ",     64'(occupancy), 64'd2);
        checkOutput("bpB_inReady", 64'(in_ready),  64'd0);
        // An offer while full must be ignored.
        applyStimulus(1'b1, 8'hEE, 32'h0000_0BAD, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("bpHold_occ",     64'(occupancy), 64'd2);
        checkOutput("bpHold_inReady", 64'(in_ready),  64'd0);
        checkOutput("bpHold_data",    64'(out_data),  64'h0000_00AA);
        checkOutput("bpHold_ctrl",    64'(out_ctrl),  64'h1A);
        checkOutput("bpHold_stall",   64'(stall_cnt), 64'd3);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        #1;
        checkOutput("bpDrainA_data", 64'(out_data), 64'h0000_00AA);
        tick();
        checkOutput("bpDrainB_valid",   64'(out_valid), 64'd1);
        checkOutput("bpDrainB_data",    64'(out_data),  64'h0000_00BB);
        checkOutput("bpDrainB_occ",     64'(occupancy), 64'd1);
        checkOutput("bpDrainB_inReady", 64'(in_ready),  64'd1);
        checkOutput("bpDrainB_stall",   64'(stall_cnt), 64'd3);
        tick();
        checkOutput("bpEmpty_valid", 64'(out_valid), 64'd0);
        checkOutput("bpEmpty_occ",   64'(occupancy), 64'd0);

        // Flush with both slots full while C is offered.
        doReset("flRst");
        applyStimulus(1'b1, 8'h0D, 32'h0000_00DD, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h0E, 32'h0000_00EE, 1'b0, 1'b0);
        tick();
        checkOutput("flFull_occ", 64'(occupancy), 64'd2);
        applyStimulus(1'b1, 8'h0C, 32'h0000_00CC, 1'b1, 1'b1);
        tick();
        checkOutput("flush_occ",     64'(occupancy), 64'd0);
        checkOutput("flush_valid",   64'(out_valid), 64'd0);
        checkOutput("flush_ctrl",    64'(out_ctrl),  64'd0);
        checkOutput("flush_inReady", 64'(in_ready),  64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("flushAfter%0d_valid", i), 64'(out_valid), 64'd0);
        end

        // Bubble zeroing: a prior entry leaves all-ones ctrl in the slot.
        doReset("bubRst");
        applyStimulus(1'b1, 8'hFF, 32'h0000_0055, 1'b1, 1'b0);
        tick();
        checkOutput("bubLive_ctrl", 64'(out_ctrl), 64'hFF);
        applyStimulus(1'b0, 8'hFF, 32'h0000_0066, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("bubble%0d_valid", i), 64'(out_valid), 64'd0);
            checkOutput($sformatf("bubble%0d_ctrl", i),  64'(out_ctrl),  64'd0);
        end

        // Saturation: 20 blocked edges on a 4-bit counter.
        doReset("satRst");
        applyStimulus(1'b1, 8'h01, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("sat14_stall", 64'(stall_cnt), 64'd14);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("sat20_stall", 64'(stall_cnt), 64'd15);
        tick();
        checkOutput("sat21_stall", 64'(stall_cnt), 64'd15);

        // Asynchronous reset between edges with both slots full.
        doReset("arRst");
        applyStimulus(1'b1, 8'h21, 32'h0000_0121, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h22, 32'h0000_0122, 1'b0, 1'b0);
        tick();
        checkOutput("arFull_occ", 64'(occupancy), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arAsync_valid",   64'(out_valid), 64'd0);
        checkOutput("arAsync_ctrl",    64'(out_ctrl),  64'd0);
        checkOutput("arAsync_data",    64'(out_data),  64'd0);
        checkOutput("arAsync_inReady", 64'(in_ready),  64'd1);
        checkOutput("arAsync_occ",     64'(occupancy), 64'd0);
        checkOutput("arAsync_stall",   64'(stall_cnt), 64'd0);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 8'h77, 32'h0000_0777, 1'b1, 1'b0);
        tick();
        checkOutput("arFirst_valid", 64'(out_valid), 64'd1);
        checkOutput("arFirst_data",  64'(out_data),  64'h0000_0777);
        checkOutput("arFirst_occ",   64'(occupancy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
